// File: rtl/spi_display_pkg.sv
// Shared constants and state encodings for the MAX7219-class display driver.
package spi_display_pkg;

    localparam logic [7:0] REG_DIGIT0 = 8'h01;
    localparam logic [7:0] REG_DECODE = 8'h09;
    localparam logic [7:0] REG_INTENS = 8'h0A;
    localparam logic [7:0] REG_SCAN   = 8'h0B;
    localparam logic [7:0] REG_SHUTDN = 8'h0C;
    localparam logic [7:0] REG_TEST   = 8'h0F;

    localparam int INIT_FRAMES = 5;

    // Sequencer (INIT / IDLE / refresh running) and serializer (IDLE / SHIFT / GAP).
    typedef enum logic [1:0] {
        SEQ_INIT,
        SEQ_IDLE,
        SEQ_REFRESH
    } seq_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } tx_state_e;

    function automatic logic [15:0] make_frame(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/spi_display_driver_tx.sv
// 16-bit SPI mode-0 frame serializer: MSB first, CS_n framing, one CLK_DIV gap.
module spi_frame_tx
    import spi_display_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic        idle_o,
    output logic        done_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        cs_n_o
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      sr_q, sr_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             cs_n_q, cs_n_d;
    logic             div_wrap;

    assign div_wrap = (div_q == DIV_LAST);
    assign idle_o   = (state_q == ST_IDLE);
    // A start accepted in the last GAP cycle chains frames with no idle cycle.
    assign done_o   = (state_q == ST_GAP) && div_wrap;
    assign sclk_o   = sclk_q;
    assign mosi_o   = mosi_q;
    assign cs_n_o   = cs_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_wrap ? '0 : div_q + 1'b1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (start_i) begin
                    state_d = ST_SHIFT;
                    sr_d    = word_i;
                    bit_d   = 4'd15;
                    mosi_d  = word_i[15];
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_wrap) begin
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        state_d = ST_GAP;
                        sclk_d  = 1'b0;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        sclk_d = 1'b0;
                        sr_d   = sr_q << 1;
                        mosi_d = sr_q[14];
                    end
                end
            end
            ST_GAP: begin
                if (div_wrap) begin
                    if (start_i) begin
                        state_d = ST_SHIFT;
                        sr_d    = word_i;
                        bit_d   = 4'd15;
                        mosi_d  = word_i[15];
                        cs_n_d  = 1'b0;
                        sclk_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/spi_display_driver.sv
// Stopwatch display driver: controller init after reset, then snapshot-based digit refreshes.
module spi_display_driver
    import spi_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int CLK_DIV    = 4,
    parameter int INTENSITY  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    update,
    output logic                    busy,
    output logic                    clk_SPI,
    output logic                    MOSI,
    output logic                    CS_n
);

    localparam logic [7:0] DECODE_MASK = 8'((1 << NUM_DIGITS) - 1);
    localparam logic [7:0] SCAN_LIMIT  = 8'(NUM_DIGITS - 1);
    localparam logic [2:0] LAST_INIT   = 3'(INIT_FRAMES - 1);
    localparam logic [2:0] LAST_DIGIT  = 3'(NUM_DIGITS - 1);

    seq_state_e              state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                    tx_start, tx_idle, tx_done;
    logic [15:0]             tx_word;
    logic [2:0]              idx_nxt;
    logic                    launch, seq_end;

    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    return make_frame(REG_TEST, 8'h00);
            3'd1:    return make_frame(REG_DECODE, DECODE_MASK);
            3'd2:    return make_frame(REG_SCAN, SCAN_LIMIT);
            3'd3:    return make_frame(REG_INTENS, {4'h0, 4'(INTENSITY)});
            default: return make_frame(REG_SHUTDN, 8'h01);
        endcase
    endfunction

    function automatic logic [15:0] digit_word(input logic [2:0] i,
                                               input logic [4*NUM_DIGITS-1:0] dig,
                                               input logic [NUM_DIGITS-1:0] pnt);
        logic [31:0] dig8;
        logic [7:0]  pnt8;
        dig8 = 32'(dig);
        pnt8 = 8'(pnt);
        return make_frame(REG_DIGIT0 + 8'(i), {pnt8[i], 3'b000, dig8[{i, 2'b00} +: 4]});
    endfunction

    assign busy = (state_q != SEQ_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_INIT;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        tx_start   = 1'b0;
        tx_word    = init_word(3'd0);
        idx_nxt    = idx_q + 3'd1;
        launch     = 1'b0;
        seq_end    = 1'b0;
        case (state_q)
            SEQ_INIT: begin
                if (tx_idle) begin
                    tx_start = 1'b1;
                    tx_word  = init_word(3'd0);
                    idx_d    = '0;
                end else if (tx_done) begin
                    if (idx_q != LAST_INIT) begin
                        tx_start = 1'b1;
                        tx_word  = init_word(idx_nxt);
                        idx_d    = idx_nxt;
                    end else begin
                        seq_end = 1'b1;
                    end
                end
            end
            SEQ_IDLE: launch = update;
            SEQ_REFRESH: begin
                if (tx_done) begin
                    if (idx_q != LAST_DIGIT) begin
                        tx_start = 1'b1;
                        tx_word  = digit_word(idx_nxt, snap_dig_q, snap_dp_q);
                        idx_d    = idx_nxt;
                    end else begin
                        seq_end = 1'b1;
                    end
                end
            end
            default: state_d = SEQ_INIT;
        endcase

        if (seq_end) begin
            if (pend_q || update) launch = 1'b1;
            else                  state_d = SEQ_IDLE;
        end

        // Frame 0 comes straight from the live inputs captured into the snapshot on this edge.
        if (launch) begin
            tx_start   = 1'b1;
            tx_word    = digit_word(3'd0, digits, dp);
            snap_dig_d = digits;
            snap_dp_d  = dp;
            idx_d      = '0;
            pend_d     = 1'b0;
            state_d    = SEQ_REFRESH;
        end else if (update && state_q != SEQ_IDLE) begin
            pend_d = 1'b1;
        end
    end

    spi_frame_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (tx_start),
        .word_i  (tx_word),
        .idle_o  (tx_idle),
        .done_o  (tx_done),
        .sclk_o  (clk_SPI),
        .mosi_o  (MOSI),
        .cs_n_o  (CS_n)
    );

endmodule

// File: tb/tb_spi_display_driver.sv
// Self-checking bench: queue-based frame-schedule model plus literal frame/duration checks.
module tb_spi_display_driver;

    localparam int D  = 4;
    localparam int N  = 6;
    localparam int FL = 33 * D;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4*N-1:0] digits = '0;
    logic [N-1:0]   dp = '0;
    logic           update = 1'b0;
    logic busy, sclk, mosi, cs_n;

    logic [3:0] digits_s = 4'h7;
    logic [0:0] dp_s = 1'b0;
    logic       update_s = 1'b0;
    logic busy_s, sclk_s, mosi_s, cs_n_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_display_driver #(.NUM_DIGITS(N), .CLK_DIV(D), .INTENSITY(8)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp(dp), .update(update),
        .busy(busy), .clk_SPI(sclk), .MOSI(mosi), .CS_n(cs_n)
    );

    spi_display_driver #(.NUM_DIGITS(1), .CLK_DIV(1), .INTENSITY(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .digits(digits_s), .dp(dp_s), .update(update_s),
        .busy(busy_s), .clk_SPI(sclk_s), .MOSI(mosi_s), .CS_n(cs_n_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model: a queue of words to send, one frame = 33*D cycles
    logic [15:0] mq[$];
    logic [15:0] m_word = '0;
    logic        m_active = 1'b0;
    int          m_el = 0;
    logic        m_busy = 1'b1;
    logic        m_pend = 1'b0;
    logic        m_init = 1'b1;
    logic        m_used = 1'b0;

    task automatic m_start();
        m_word   = mq.pop_front();
        m_active = 1'b1;
        m_el     = 0;
    endtask

    task automatic m_load_refresh();
        logic [3:0] nib;
        logic       pt;
        for (int i = 0; i < N; i++) begin
            nib = 4'(digits >> (4 * i));
            pt  = 1'(dp >> i);
            mq.push_back({8'(i + 1), pt, 3'b000, nib});
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_active = 1'b0;
            m_el     = 0;
            m_busy   = 1'b1;
            m_pend   = 1'b0;
            m_init   = 1'b1;
        end else begin
            m_used = 1'b0;
            if (m_active) begin
                m_el++;
                if (m_el == FL) m_active = 1'b0;
            end
            if (m_init) begin
                m_init = 1'b0;
                mq.push_back(16'h0F00);
                mq.push_back({8'h09, 8'((1 << N) - 1)});
                mq.push_back({8'h0B, 8'(N - 1)});
                mq.push_back(16'h0A08);
                mq.push_back(16'h0C01);
                m_start();
            end else if (!m_active && m_busy) begin
                if (mq.size() > 0) begin
                    m_start();
                end else if (m_pend || update) begin
                    m_load_refresh();
                    m_pend = 1'b0;
                    m_used = 1'b1;
                    m_start();
                end else begin
                    m_busy = 1'b0;
                end
            end else if (!m_busy && update) begin
                m_load_refresh();
                m_busy = 1'b1;
                m_used = 1'b1;
                m_start();
            end
            if (update && !m_used && m_busy) m_pend = 1'b1;
        end
    end

    // ---------------- per-cycle compare + SPI slave decoders
    logic [15:0] fr_m[$];
    logic [15:0] fr_s[$];
    logic [15:0] ex[$];
    logic [15:0] d_sh = '0, s_sh = '0;
    int          d_bits = 0, s_bits = 0;
    logic        p_sclk = 1'b0, p_cs = 1'b1, ps_sclk = 1'b0, ps_cs = 1'b1;
    int          tcyc = 0;
    int          s_fall[2];
    int          s_nf = 0;
    int          s_run = 0, s_maxrun = 0;

    initial forever begin
        logic e_cs, e_sclk, e_mosi;
        @(negedge clk);
        tcyc++;
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
        if (m_active && m_el < 32 * D) begin
            e_cs   = 1'b0;
            e_sclk = ((m_el % (2 * D)) >= D);
            e_mosi = m_word[15 - m_el / (2 * D)];
        end
        check("cycle{busy,cs_n,sclk,mosi}", 32'({busy, cs_n, sclk, mosi}),
              32'({m_busy, e_cs, e_sclk, e_mosi}));

        if (!rst_n) begin
            d_bits = 0;
            s_bits = 0;
        end else begin
            if (!cs_n && sclk && !p_sclk) begin d_sh = {d_sh[14:0], mosi}; d_bits++; end
            if (cs_n && !p_cs) begin
                if (d_bits == 16) fr_m.push_back(d_sh);
                d_bits = 0;
            end
            if (!cs_n_s && sclk_s && !ps_sclk) begin s_sh = {s_sh[14:0], mosi_s}; s_bits++; end
            if (cs_n_s && !ps_cs) begin
                if (s_bits == 16) fr_s.push_back(s_sh);
                s_bits = 0;
            end
            if (!cs_n_s && ps_cs) begin
                if (s_nf < 2) s_fall[s_nf] = tcyc;
                s_nf++;
            end
            if (sclk_s) begin
                s_run++;
                if (s_run > s_maxrun) s_maxrun = s_run;
            end else begin
                s_run = 0;
            end
        end
        p_sclk = sclk; p_cs = cs_n; ps_sclk = sclk_s; ps_cs = cs_n_s;
    end

    // ---------------- directed stimulus
    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_err++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", limit);
        end
    endtask

    task automatic check_frames(input string name);
        check({name, "_count"}, 32'(fr_m.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size(); i++)
            if (i < fr_m.size()) check(name, 32'(fr_m[i]), 32'(ex[i]));
        fr_m.delete();
        ex.delete();
    endtask

    task automatic push_init_main();
        ex.push_back(16'h0F00); ex.push_back(16'h093F); ex.push_back(16'h0B05);
        ex.push_back(16'h0A08); ex.push_back(16'h0C01);
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_s_cs_n", 32'(cs_n_s), 32'd1);

        // init sequence after reset release
        @(negedge clk);
        rst_n = 1'b1;
        fr_m.delete(); fr_s.delete(); s_nf = 0; s_maxrun = 0;
        @(negedge clk);
        wait_idle(3000, n);
        check("init_busy_len", 32'(n), 32'd660);
        push_init_main();
        check_frames("init_frame");

        // CLK_DIV=1, NUM_DIGITS=1 instance finished its init long ago
        check("s_frame_count", 32'(fr_s.size()), 32'd5);
        ex.push_back(16'h0F00); ex.push_back(16'h0901); ex.push_back(16'h0B00);
        ex.push_back(16'h0A08); ex.push_back(16'h0C01);
        for (int i = 0; i < 5; i++)
            if (i < fr_s.size()) check("s_init_frame", 32'(fr_s[i]), 32'(ex[i]));
        ex.delete();
        check("s_frame_period", 32'(s_fall[1] - s_fall[0]), 32'd33);
        check("s_sclk_high_run", 32'(s_maxrun), 32'd1);

        // single refresh
        digits = 24'h123456;
        dp     = 6'b000100;
        pulse_update();
        wait_idle(3000, n);
        check("refresh_busy_len", 32'(n), 32'd792);
        ex.push_back(16'h0106); ex.push_back(16'h0205); ex.push_back(16'h0384);
        ex.push_back(16'h0403); ex.push_back(16'h0502); ex.push_back(16'h0601);
        check_frames("refresh_frame");

        // inputs change mid-refresh; snapshot must hold
        digits = 24'h987654;
        dp     = '0;
        pulse_update();
        repeat (400) @(negedge clk);
        digits = 24'h000000;
        dp     = '1;
        wait_idle(3000, n);
        ex.push_back(16'h0104); ex.push_back(16'h0205); ex.push_back(16'h0306);
        ex.push_back(16'h0407); ex.push_back(16'h0508); ex.push_back(16'h0609);
        check_frames("snapshot_frame");

        // three requests during one refresh -> exactly one more refresh
        digits = 24'h000001;
        dp     = '0;
        pulse_update();
        repeat (99) @(negedge clk);
        digits = 24'h000002;
        for (int k = 0; k < 3; k++) begin
            pulse_update();
            repeat (99) @(negedge clk);
        end
        wait_idle(3000, n);
        check("pending_busy_len", 32'(399 + n), 32'd1584);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++)
                ex.push_back({8'(i + 1), (i == 0) ? 8'(r + 1) : 8'h00});
        check_frames("pending_frame");

        // reset during bit 7 of init frame 2, with a request pending from INIT
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fr_m.delete();
        @(negedge clk);
        for (int j = 1; j <= 330; j++) begin
            @(negedge clk);
            update = (j == 50);
        end
        check("pre_rst_cs_n", 32'(cs_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs_n", 32'(cs_n), 32'd1);
        check("abort_sclk", 32'(sclk), 32'd0);
        check("abort_mosi", 32'(mosi), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fr_m.delete();
        @(negedge clk);
        wait_idle(3000, n);
        check("reinit_busy_len", 32'(n), 32'd660);
        push_init_main();
        check_frames("reinit_frame");

        // request during INIT chains a refresh straight after it
        rst_n = 1'b0;
        digits = 24'h000042;
        dp     = 6'b100000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fr_m.delete();
        @(negedge clk);
        repeat (9) @(negedge clk);
        pulse_update();
        wait_idle(3000, n);
        check("init_pend_busy_len", 32'(10 + n), 32'd1452);
        push_init_main();
        ex.push_back(16'h0102); ex.push_back(16'h0204); ex.push_back(16'h0300);
        ex.push_back(16'h0400); ex.push_back(16'h0500); ex.push_back(16'h0680);
        check_frames("init_pend_frame");

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_display_driver.md
# spi_display_driver

Parametrised serial display driver for the stopwatch. It takes a vector of BCD digits plus decimal-point flags and pushes them to a MAX7219-class 7-segment controller over a write-only SPI link (clk_SPI, MOSI, CS_n). After reset it autonomously runs the controller's configuration sequence, then refreshes all digits on each update request. It sits between the time-keeping counters and the chip pins, replacing the fixed minutes/seconds/centiseconds serializer.

## Interface

Parameters:
- NUM_DIGITS, 6: number of displayed digits; legal range 1..8.
- CLK_DIV, 4: clk cycles per SPI half-period; legal range ≥1.
- INTENSITY, 8: 4-bit brightness value written at init.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- digits  in  4*NUM_DIGITS  BCD digits; nibble i → display digit i (i=0 rightmost, controller address i+1).
- dp  in  NUM_DIGITS  decimal-point flags, bit i → bit 7 of digit i data byte.
- update  in  1  single-cycle refresh request.
- busy  out  1  high while init or a refresh is in progress.
- clk_SPI  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  serial data, MSB first.
- CS_n  out  1  chip select / LOAD, active low.

## Operation

- Frame: 16 bits, {addr[7:0], data[7:0]}, MSB first.
- FSM states: INIT, IDLE, SHIFT, GAP.
- INIT: entered on reset. Sends 5 frames in order: 0x0F00 (test off), 0x09 + ((1<<NUM_DIGITS)-1) (code-B decode on used digits), 0x0B + (NUM_DIGITS-1) (scan limit), 0x0A + INTENSITY, 0x0C01 (leave shutdown). Then IDLE.
- IDLE: busy=0. When update=1, snapshot digits and dp into internal registers, then send NUM_DIGITS frames, address 1..NUM_DIGITS. Each data byte is {dp[i], 3'b000, digits[4i+3:4i]}.
- Nibbles >9 are forwarded unchanged; the controller's code-B decoding applies.
- Snapshot is taken once per refresh, so inputs that change mid-refresh never tear the display.
- update while busy (including during INIT) sets a 1-deep pending flag. Further requests merge into it. When the current sequence ends, a new refresh starts immediately from a fresh snapshot, and busy stays high throughout.
- update in the same cycle the last GAP ends counts as pending, so no request is ever lost.
- Async reset mid-frame aborts the frame, and outputs go to reset values. On release, INIT restarts from frame 0 and the pending flag is cleared.

## Timing

- Reset values: clk_SPI=0, MOSI=0, CS_n=1, busy=1.
- INIT begins on the first clk edge after rst_n rises.
- Bit cell: MOSI and CS_n change on the clk edge where clk_SPI goes low. clk_SPI is low for CLK_DIV cycles, then high for CLK_DIV cycles. The slave samples on the rising clk_SPI edge, with MOSI stable for CLK_DIV cycles beforehand.
- CS_n falls together with bit 15 being driven.
- After bit 0's high phase, clk_SPI returns low and CS_n rises together (the LOAD edge). CS_n then stays high for CLK_DIV cycles (GAP) before the next frame.
- Frame length is 33*CLK_DIV clk cycles.
- Refresh length is NUM_DIGITS*33*CLK_DIV; init length is 165*CLK_DIV.
- Latency from update (sampled in IDLE) to CS_n low is 1 cycle.
- busy rises in the cycle after update is sampled. It falls in the cycle after the last GAP completes, unless a request is pending.
- MOSI is 0 while CS_n is high.
- Divider counter width is $clog2(CLK_DIV+1). Bit counter is 4 bits. Frame index counter is 3 bits.

## Structure

- Shared package spi_display_pkg holds:
  - register address constants: REG_DIGIT0=0x01, REG_DECODE=0x09, REG_INTENS=0x0A, REG_SCAN=0x0B, REG_SHUTDN=0x0C, REG_TEST=0x0F;
  - the FSM state encoding;
  - INIT_FRAMES=5.
- Sub-module spi_frame_tx: a 16-bit serializer with divider. Its interface is start/word in, done pulse, and clk_SPI, MOSI, CS_n out; it owns the SHIFT/GAP timing.
- The top level owns INIT/IDLE sequencing, the snapshot, the pending flag and frame-word muxing.

## Test plan

- Reset release, NUM_DIGITS=6, CLK_DIV=4 → 5 frames decoded as 0x0F00, 0x093F, 0x0B05, 0x0A08, 0x0C01; busy falls 660 cycles after the first clk edge.
- IDLE, digits=0x123456, dp=6'b000100, one update pulse → frames 0x0106, 0x0205, 0x0384, 0x0403, 0x0502, 0x0601; busy high for exactly 792 cycles.
- Change digits at the midpoint of a refresh → all remaining frames carry the snapshot values.
- Three update pulses during one refresh → exactly one extra refresh follows, with busy continuously high.
- rst_n low during bit 7 of frame 2 → CS_n=1, clk_SPI=0, MOSI=0 immediately; after release, the full INIT sequence is reissued.
- CLK_DIV=1, NUM_DIGITS=1 → each clk_SPI half-period is 1 cycle, the frame is 33 cycles, init emits decode 0x0901 and scan 0x0B00.
